// File: rtl/counter_cmd_sequencer.sv
// Drives an up/down counter from CLEAR/LOAD/RAMP/NOP commands and checks the readback; done/err pulse 1 cycle after CHECK.
// Latency NOP 1, CLEAR/LOAD 2, RAMP(N) N+2 edges; cmd_ready is high only in IDLE, so a held cmd_valid waits.
module counter_cmd_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cnt_clear,
    output logic             cnt_load,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] cnt_d,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             done,
    output logic             err,
    output logic [WIDTH:0]   ramp_steps
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CLR,
        S_LD,
        S_RAMP,
        S_CHECK
    } state_t;

    localparam logic [1:0]     OP_CLEAR   = 2'b00;
    localparam logic [1:0]     OP_LOAD    = 2'b01;
    localparam logic [1:0]     OP_RAMP    = 2'b10;
    localparam logic [WIDTH:0] STEP_LIMIT = {1'b1, {WIDTH{1'b0}}};

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH:0]   r_step;
    logic             r_tmo;
    logic             r_done;
    logic             r_err;
    logic [WIDTH:0]   r_ramp_steps;

    logic w_accept;
    logic w_at_target;
    logic w_step_max;
    logic w_up;

    assign cmd_ready   = (r_state == S_IDLE);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_at_target = (cnt_q == r_data);
    assign w_step_max  = (r_step == STEP_LIMIT);
    assign w_up        = (r_data > cnt_q);
    assign done        = r_done;
    assign err         = r_err;
    assign ramp_steps  = r_ramp_steps;

    // The counter has no enable, so "hold" means reloading its own output.
    always_comb begin
        cnt_clear   = 1'b0;
        cnt_load    = 1'b1;
        cnt_up_down = 1'b0;
        cnt_d       = cnt_q;
        case (r_state)
            S_INIT, S_CLR: begin
                cnt_clear = 1'b1;
                cnt_load  = 1'b0;
            end
            S_LD: cnt_d = r_data;
            S_RAMP: begin
                if (!w_at_target && !w_step_max) begin
                    cnt_load    = 1'b0;
                    cnt_up_down = w_up;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_op         <= '0;
            r_data       <= '0;
            r_exp        <= '0;
            r_step       <= '0;
            r_tmo        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ramp_steps <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_INIT: r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        r_tmo  <= 1'b0;
                        case (cmd_op)
                            OP_CLEAR: begin
                                r_exp   <= '0;
                                r_state <= S_CLR;
                            end
                            OP_LOAD: begin
                                r_exp   <= cmd_data;
                                r_state <= S_LD;
                            end
                            OP_RAMP: begin
                                r_exp   <= cmd_data;
                                r_step  <= '0;
                                r_state <= S_RAMP;
                            end
                            default: begin
                                r_exp   <= cnt_q;
                                r_state <= S_CHECK;
                            end
                        endcase
                    end
                end
                S_CLR, S_LD: r_state <= S_CHECK;
                S_RAMP: begin
                    if (w_at_target) begin
                        r_state <= S_CHECK;
                    end else if (w_step_max) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_CHECK;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_done <= 1'b1;
                    r_err  <= (cnt_q != r_exp) | r_tmo;
                    if (r_op == OP_RAMP) begin
                        r_ramp_steps <= r_step;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench: behavioural counter stub plus a command-level model of done/err/ramp_steps/ready timing.
module tb_counter_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cnt_clear;
    logic       cnt_load;
    logic       cnt_up_down;
    logic [7:0] cnt_d;
    logic [7:0] cnt_q;
    logic       done;
    logic       err;
    logic [8:0] ramp_steps;

    logic [7:0] r_cnt;
    logic       stuck;
    logic       chk_en;

    int nvec;
    int nerr;

    counter_cmd_sequencer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cnt_clear  (cnt_clear),
        .cnt_load   (cnt_load),
        .cnt_up_down(cnt_up_down),
        .cnt_d      (cnt_d),
        .cnt_q      (cnt_q),
        .done       (done),
        .err        (err),
        .ramp_steps (ramp_steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit up/down counter; stuck forces the readback to zero.
    always @(posedge clk) begin
        if (cnt_clear)     r_cnt <= 8'h00;
        else if (cnt_load) r_cnt <= cnt_d;
        else if (cnt_up_down) r_cnt <= r_cnt + 8'h01;
        else               r_cnt <= r_cnt - 8'h01;
    end
    assign cnt_q = stuck ? 8'h00 : r_cnt;

    // Command-level reference model.
    localparam int PH_INIT = 0, PH_IDLE = 1, PH_BUSY = 2;
    int         m_phase;
    int         m_left;
    logic       m_done, m_err;
    int         m_steps;
    logic [7:0] m_cnt;
    logic       p_err, p_ramp;
    int         p_rsteps;
    logic [7:0] p_final;

    initial begin
        m_phase = PH_INIT; m_done = 0; m_err = 0; m_steps = 0; m_cnt = 0; m_left = 0;
        p_err = 0; p_ramp = 0; p_rsteps = 0; p_final = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = PH_INIT; m_done = 0; m_err = 0; m_steps = 0;
            end else begin
                m_done = 0;
                m_err  = 0;
                case (m_phase)
                    PH_INIT: begin
                        m_phase = PH_IDLE;
                        m_cnt   = 8'h00;
                    end
                    PH_IDLE: if (cmd_valid) begin
                        int d, c;
                        d = int'(cmd_data);
                        c = int'(m_cnt);
                        p_ramp = 0;
                        p_err  = 0;
                        case (cmd_op)
                            2'b00: begin p_final = 8'h00; m_left = 2; end
                            2'b01: begin p_final = cmd_data; p_err = stuck && (d != 0); m_left = 2; end
                            2'b10: begin
                                p_ramp  = 1;
                                p_final = cmd_data;
                                if (stuck) begin
                                    p_rsteps = (d == 0) ? 0 : 256;
                                    p_err    = (d != 0);
                                end else begin
                                    p_rsteps = (d >= c) ? d - c : c - d;
                                end
                                m_left = p_rsteps + 2;
                            end
                            default: begin p_final = m_cnt; m_left = 1; end
                        endcase
                        m_phase = PH_BUSY;
                    end
                    default: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_done = 1;
                            m_err  = p_err;
                            if (p_ramp) m_steps = p_rsteps;
                            m_cnt   = p_final;
                            m_phase = PH_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cmd_ready", 32'(cmd_ready), 32'(m_phase == PH_IDLE));
            cmp("done", 32'(done), 32'(m_done));
            cmp("err", 32'(err), 32'(m_err));
            cmp("ramp_steps", 32'(ramp_steps), 32'(m_steps));
            if (m_phase == PH_IDLE && !stuck)
                cmp("cnt_q_hold", 32'(cnt_q), 32'(m_cnt));
        end
    end

    // Issue one command from an idle negedge; returns edges-to-done and the done-cycle outputs.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           output int lat, output logic e, output logic [8:0] st);
        lat = -1; e = 0; st = 0;
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k; e = err; st = ramp_steps;
                break;
            end
        end
        if (lat < 0) cmp("done_timeout", 32'd0, 32'd1);
    endtask

    int         lat;
    logic       e;
    logic [8:0] st;
    int         seen;

    initial begin
        nvec = 0; nerr = 0; chk_en = 0; stuck = 0;
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_data = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        cmp("rst_ready", 32'(cmd_ready), 32'd0);
        cmp("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("init_cnt", 32'(cnt_q), 32'h00);
        cmp("init_ready", 32'(cmd_ready), 32'd1);

        run_cmd(2'b01, 8'h12, lat, e, st);
        cmp("load_lat", 32'(lat), 32'd2);
        cmp("load_err", 32'(e), 32'd0);
        cmp("load_val", 32'(cnt_q), 32'h12);
        repeat (100) @(negedge clk);
        cmp("hold_val", 32'(cnt_q), 32'h12);

        run_cmd(2'b10, 8'h15, lat, e, st);
        cmp("rampup_lat", 32'(lat), 32'd5);
        cmp("rampup_steps", 32'(st), 32'd3);
        cmp("rampup_err", 32'(e), 32'd0);
        run_cmd(2'b10, 8'h10, lat, e, st);
        cmp("rampdn_lat", 32'(lat), 32'd7);
        cmp("rampdn_steps", 32'(st), 32'd5);
        cmp("rampdn_val", 32'(cnt_q), 32'h10);
        run_cmd(2'b10, 8'h10, lat, e, st);
        cmp("ramp0_lat", 32'(lat), 32'd2);
        cmp("ramp0_steps", 32'(st), 32'd0);
        run_cmd(2'b11, 8'hEE, lat, e, st);
        cmp("nop_lat", 32'(lat), 32'd1);
        cmp("nop_err", 32'(e), 32'd0);

        stuck = 1;
        run_cmd(2'b01, 8'hA5, lat, e, st);
        cmp("stuck_load_lat", 32'(lat), 32'd2);
        cmp("stuck_load_err", 32'(e), 32'd1);
        run_cmd(2'b10, 8'h03, lat, e, st);
        cmp("tmo_lat", 32'(lat), 32'd258);
        cmp("tmo_steps", 32'(st), 32'd256);
        cmp("tmo_err", 32'(e), 32'd1);
        run_cmd(2'b00, 8'h00, lat, e, st);
        cmp("stuck_clr_err", 32'(e), 32'd0);
        stuck = 0;

        run_cmd(2'b01, 8'h40, lat, e, st);
        cmd_op = 2'b10; cmd_data = 8'h80; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        cmp("abort_done", 32'(done), 32'd0);
        cmp("abort_err", 32'(err), 32'd0);
        cmp("abort_ready", 32'(cmd_ready), 32'd0);
        cmp("abort_steps", 32'(ramp_steps), 32'd0);
        cmd_op = 2'b01; cmd_data = 8'h33; cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) cmp("abort_cnt", 32'(cnt_q), 32'h00);
            if (done) begin
                seen = k;
                break;
            end
        end
        cmd_valid = 1'b0;
        cmp("held_valid_lat", 32'(seen), 32'd4);
        cmp("held_valid_val", 32'(cnt_q), 32'h33);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (m_phase == PH_IDLE) begin
                seen = 1;
                break;
            end
        end
        cmp("drain_idle", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
Command-driven controller that sits on the control side of the 8-bit behavioural up/down counter and drives its clear, load, up_down and d inputs. It reads back the counter value qd. It accepts CLEAR, LOAD, RAMP and NOP commands over a valid/ready handshake, executes them on the counter, and checks that the counter reached the expected value. Because the counter has no hold/enable input, the sequencer holds the count by reloading qd every idle cycle.

Parameters:
WIDTH, 8, counter data width; must match the counter instance.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
cmd_valid  input  1  command request.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  2  00=CLEAR, 01=LOAD, 10=RAMP, 11=NOP.
cmd_data  input  WIDTH  LOAD value or RAMP target; ignored for CLEAR/NOP.
cnt_clear  output  1  to counter clear.
cnt_load  output  1  to counter load.
cnt_up_down  output  1  to counter up_down (1=up).
cnt_d  output  WIDTH  to counter d.
cnt_q  input  WIDTH  from counter qd.
done  output  1  one-cycle pulse: command complete.
err  output  1  one-cycle pulse, coincident with done: readback mismatch or ramp timeout.
ramp_steps  output  WIDTH+1  count steps issued by the last RAMP; holds until the next RAMP.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=INIT, cmd_ready=0, done=0, err=0, ramp_steps=0.
  - Latched op and data = 0.
- States: INIT, IDLE, CLR, LD, RAMP, CHECK.
- Counter control outputs:
  - cnt_clear, cnt_load, cnt_up_down and cnt_d are combinational from state, latched data and cnt_q (Mealy).
  - This lets a RAMP stop exactly on target.
  - Default values: clear=0, load=1, d=cnt_q (hold), up_down=0.
  - In every state the clear/load/up_down combination is one the counter decodes unambiguously; clear and load are never both 1.
- INIT: cnt_clear=1, cnt_load=0 for one cycle -> IDLE. The counter therefore reads 0 after the first post-reset edge.
- IDLE:
  - Default hold outputs; cmd_ready=1.
  - On cmd_valid & cmd_ready, latch op and data, then go to:
    - CLEAR -> CLR
    - LOAD -> LD
    - RAMP -> RAMP; also clear the ramp step counter to 0.
    - NOP -> CHECK, with expected value = cnt_q at acceptance.
- cmd_ready=0 in every state except IDLE. A command held valid while busy is taken on the first IDLE cycle.
- CLR: cnt_clear=1, cnt_load=0 -> CHECK, expected value 0.
- LD: cnt_load=1, cnt_d=data -> CHECK, expected value data.
- RAMP, each cycle:
  - If cnt_q==data: hold outputs -> CHECK, expected value data.
  - Else: cnt_load=0, cnt_up_down=(data>cnt_q, unsigned), and step counter +1.
  - If the step counter reaches 2^WIDTH before equality: hold outputs -> CHECK with err forced.
  - Ramp never wraps: direction is chosen by unsigned compare, so the path is always the direct one (0x00->0xFF takes 255 down? no: 255 up steps).
- CHECK:
  - Hold outputs; compare cnt_q to the expected value; -> IDLE.
  - Registered done=1 and err=(mismatch | timeout) in the following cycle, high for exactly one cycle.
  - cmd_ready=1 in that same cycle.
  - On a RAMP, ramp_steps is updated to the step count when done asserts.
- Latency, from the acceptance edge E0:
  - CLEAR/LOAD: done high between E2 and E3.
  - NOP: done high between E1 and E2.
  - RAMP of distance N: done high between E(N+2) and E(N+3).
- Reset asserted mid-command: abort immediately to INIT, with no done/err. The counter is cleared on the next edge after release.

Test Plan:
1. Reset release -> INIT clears counter: qd=0x00 one edge later; cmd_ready rises the next cycle; done/err stay 0.
2. LOAD 0x12 -> qd=0x12 after one edge; done=1, err=0 two edges after accept. qd then stays 0x12 for 100 idle cycles (hold by reload).
3. RAMP 0x15 from 0x12 -> up_down=1 for 3 cycles; qd 0x13, 0x14, 0x15 then holds; done at E5, ramp_steps=3, err=0.
4. RAMP 0x10 from 0x15 -> 5 down steps, qd=0x10, ramp_steps=5. Then RAMP 0x10 again -> ramp_steps=0, done at E2.
5. Force cnt_q stuck at 0x00 (counter stubbed), issue LOAD 0xA5 -> done=1 with err=1. RAMP 0x03 -> timeout after 256 steps, err=1.
6. rst_n pulsed low mid-RAMP (qd=0x40 toward 0x80) -> outputs reset asynchronously, no done pulse, qd=0x00 after release. cmd_valid held high during busy is accepted only on the first IDLE cycle.
